// File: rtl/segment_display_sched_if.sv
// Source-side and display-side signals of the segment display scheduler.
interface segment_display_sched_if #(
  parameter int unsigned N_SRC = 4
);
  logic [N_SRC*8-1:0] src_data;
  logic [N_SRC-1:0]   src_upd;
  logic [N_SRC-1:0]   src_en;
  logic               hold;
  logic [7:0]         disp_count;
  logic [1:0]         disp_sel;
  logic               disp_blank;
  logic               disp_stb;

  // Count producers and the display consumer
  modport master (
    output src_data, src_upd, src_en, hold,
    input  disp_count, disp_sel, disp_blank, disp_stb
  );

  // The scheduler itself
  modport slave (
    input  src_data, src_upd, src_en, hold,
    output disp_count, disp_sel, disp_blank, disp_stb
  );
endinterface

// File: rtl/segment_display_sched.sv
// Round-robin time-sharing of a two-digit segment display among up to four
// count sources. Each source's count is captured into a shadow register on
// its update pulse; enabled sources are shown in turn for DWELL cycles each.
module segment_display_sched #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned DWELL = 50000000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  segment_display_sched_if.slave  bus
);

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NEXT = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [SEL_W-1:0] cur, cur_d;
  logic [DW-1:0]    dwell, dwell_d;
  logic [7:0]       count_q, count_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             blank_q, blank_d;
  logic             stb_q, stb_d;

  logic [7:0]       slice  [N_SRC];
  logic [7:0]       shadow [N_SRC];
  logic [SEL_W-1:0] nxt;

  // Split the packed source bus into per-source counts
  for (genvar g = 0; g < N_SRC; g++) begin : g_slice
    assign slice[g] = bus.src_data[8*g +: 8];
  end

  // Shadow capture on each source's update pulse, independent of state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_SRC; i++) shadow[i] <= 8'd0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (bus.src_upd[i]) shadow[i] <= slice[i];
      end
    end
  end

  // Next enabled source after cur, wrapping, ending at cur itself
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    found = 1'b0;
    nxt   = cur;
    idx   = cur;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = SEL_W'((32'(cur) + 32'(k)) % N_SRC);
      if (!found && bus.src_en[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end

  // State and display registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      cur     <= SEL_W'(N_SRC - 1);
      dwell   <= '0;
      count_q <= 8'd0;
      sel_q   <= '0;
      blank_q <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      state   <= state_d;
      cur     <= cur_d;
      dwell   <= dwell_d;
      count_q <= count_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      stb_q   <= stb_d;
    end
  end

  // Next-state and next display values
  always_comb begin
    state_d = state;
    cur_d   = cur;
    dwell_d = dwell;
    count_d = count_q;
    sel_d   = sel_q;
    blank_d = blank_q;
    stb_d   = 1'b0;

    case (state)
      IDLE: begin
        blank_d = 1'b1;
        count_d = 8'd0;
        sel_d   = '0;
        if (|bus.src_en) state_d = NEXT;
      end

      NEXT: begin
        if (bus.src_en == '0) begin
          state_d = IDLE;
          blank_d = 1'b1;
          count_d = 8'd0;
          sel_d   = '0;
        end else begin
          state_d = SHOW;
          cur_d   = nxt;
          sel_d   = nxt;
          // Bypass the shadow when the new source updates this very cycle
          count_d = bus.src_upd[nxt] ? slice[nxt] : shadow[nxt];
          blank_d = 1'b0;
          stb_d   = 1'b1;
          dwell_d = '0;
        end
      end

      SHOW: begin
        if (!bus.hold && (dwell != DWELL_LAST)) dwell_d = dwell + DW'(1);
        if (bus.src_upd[cur]) begin
          count_d = slice[cur];
          stb_d   = 1'b1;
        end
        if (bus.src_en == '0) begin
          state_d = IDLE;
          blank_d = 1'b1;
          count_d = 8'd0;
          sel_d   = '0;
          stb_d   = 1'b0;
        end else if (!bus.src_en[cur]) begin
          state_d = NEXT;
        end else if (!bus.hold && (dwell == DWELL_LAST)) begin
          state_d = NEXT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.disp_count = count_q;
  assign bus.disp_sel   = sel_q;
  assign bus.disp_blank = blank_q;
  assign bus.disp_stb   = stb_q;

endmodule

// File: tb/tb_segment_display_sched.sv
// Directed bench for segment_display_sched with DWELL=4: rotation order,
// latencies, in-place updates, hold, single-source and reset behaviour.
module tb_segment_display_sched;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned DWELL = 4;
  localparam int PERIOD = DWELL + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  segment_display_sched_if #(.N_SRC(N_SRC)) bus ();

  segment_display_sched #(.N_SRC(N_SRC), .DWELL(DWELL)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until the next strobe; 99 when none arrives within the budget
  task automatic wait_stb(output int n);
    n = 99;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.disp_stb) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_disp(input string tag, input int sel, input int cnt);
    check_eq({tag, "_sel"}, 32'(bus.disp_sel), 32'(sel));
    check_eq({tag, "_count"}, 32'(bus.disp_count), 32'(cnt));
  endtask

  initial begin
    int n;
    int stbs;
    int exp_sel[5];
    int exp_cnt[5];
    exp_sel = '{0, 1, 2, 3, 0};
    exp_cnt = '{12, 34, 56, 78, 12};
    checks   = 0;
    failures = 0;

    rst = 1'b1;
    bus.src_data = '0;
    bus.src_upd  = '0;
    bus.src_en   = '0;
    bus.hold     = 1'b0;
    #1;
    check_eq("rst_blank", 32'(bus.disp_blank), 1);
    check_eq("rst_count", 32'(bus.disp_count), 0);
    check_eq("rst_sel",   32'(bus.disp_sel), 0);
    check_eq("rst_stb",   32'(bus.disp_stb), 0);
    step();
    step();
    rst = 1'b0;

    // 1: no sources enabled -> stays blank, never strobes
    stbs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.disp_stb) stbs++;
    end
    check_eq("idle_stbs",  32'(stbs), 0);
    check_eq("idle_blank", 32'(bus.disp_blank), 1);
    check_eq("idle_count", 32'(bus.disp_count), 0);

    // 2: load all shadows, full rotation
    bus.src_data = {8'd78, 8'd56, 8'd34, 8'd12};
    bus.src_upd  = 4'b1111;
    step();
    bus.src_upd  = '0;
    bus.src_data = '0;
    bus.src_en   = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_stb(n);
      check_eq($sformatf("rot%0d_gap", r), 32'(n), (r == 0) ? 2 : PERIOD);
      check_disp($sformatf("rot%0d", r), exp_sel[r], exp_cnt[r]);
      if (r == 0) check_eq("rot_blank", 32'(bus.disp_blank), 0);
    end

    // 3: current source dropped from the mask mid-dwell
    bus.src_en = 4'b0101;
    wait_stb(n);
    check_eq("drop_pre_gap", 32'(n), PERIOD);
    check_disp("drop_pre", 2, 56);
    bus.src_en = 4'b0001;
    wait_stb(n);
    check_eq("drop_gap", 32'(n), 2);
    check_disp("drop", 0, 12);
    wait_stb(n);
    check_eq("drop_restart_gap", 32'(n), PERIOD);
    check_disp("drop_restart", 0, 12);

    // 4: in-place update of the shown source
    bus.src_en = 4'b0010;
    wait_stb(n);
    check_eq("upd_pre_gap", 32'(n), 2);
    check_disp("upd_pre", 1, 34);
    step();
    step();
    bus.src_data = {8'd1, 8'd2, 8'd200, 8'd255};
    bus.src_upd  = 4'b0010;
    step();
    bus.src_upd  = '0;
    bus.src_data = '0;
    check_eq("upd_stb", 32'(bus.disp_stb), 1);
    check_disp("upd", 1, 200);
    wait_stb(n);
    check_eq("upd_dwell_gap", 32'(n), 2);
    check_disp("upd_post", 1, 200);

    // 5: hold freezes rotation, resumes from the held dwell count
    bus.src_en = 4'b1111;
    step();
    bus.hold = 1'b1;
    stbs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.disp_stb) stbs++;
    end
    check_eq("hold_stbs", 32'(stbs), 0);
    check_eq("hold_sel", 32'(bus.disp_sel), 1);
    bus.hold = 1'b0;
    wait_stb(n);
    check_eq("hold_resume_gap", 32'(n), 4);
    check_disp("hold_resume", 2, 56);

    // 6: single source re-selects itself each dwell
    bus.src_en = 4'b1000;
    wait_stb(n);
    check_eq("single_gap0", 32'(n), 2);
    check_disp("single0", 3, 78);
    for (int r = 1; r < 3; r++) begin
      wait_stb(n);
      check_eq($sformatf("single_gap%0d", r), 32'(n), PERIOD);
      check_disp($sformatf("single%0d", r), 3, 78);
    end
    bus.src_en = '0;
    step();
    check_eq("off_blank", 32'(bus.disp_blank), 1);
    check_eq("off_stb", 32'(bus.disp_stb), 0);
    check_disp("off", 0, 0);

    // Re-enable, then reset asynchronously mid-SHOW
    bus.src_en = 4'b1000;
    wait_stb(n);
    check_eq("reen_gap", 32'(n), 2);
    check_disp("reen", 3, 78);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_blank", 32'(bus.disp_blank), 1);
    check_eq("midrst_stb", 32'(bus.disp_stb), 0);
    check_disp("midrst", 0, 0);
    #2;
    rst = 1'b0;

    // After reset: lowest enabled source first, shadows cleared
    bus.src_en = 4'b0110;
    wait_stb(n);
    check_eq("post_rst_gap", 32'(n), 2);
    check_disp("post_rst", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
